arbitro_compuertas: RTL and testbench
=====================================

# arbitro_compuertas

Two-requester arbiter and sequencer for a shared, registered bitwise logic unit. The unit implements the eight standard gate operations: AND, OR, XOR, NOT, NAND, YES, NOR and XNOR. Each requester presents an operation and two operands over a valid/ready handshake. The block grants one requester, latches its request, computes the result in one cycle and holds it on a valid/ready result port until it is consumed. It sits between the course's gate datapath and any two producers that need to share it.

## Interface
Parameters:
- ANCHO, 4, operand and result width in bits.

Ports:
- reloj  in  1  single clock; all state updates on its rising edge.
- reinicio  in  1  asynchronous, active-high reset.
- sol0_valido  in  1  requester 0 has a pending request.
- sol0_listo  out  1  requester 0 is granted; the request transfers on this cycle.
- sol0_op  in  3  requester 0 operation code.
- sol0_a, sol0_b  in  ANCHO  requester 0 operands.
- sol1_valido, sol1_listo, sol1_op, sol1_a, sol1_b  same widths and roles for requester 1.
- res_valido  out  1  result available.
- res_listo  in  1  consumer accepts the result.
- res_dato  out  ANCHO  registered result.
- res_origen  out  1  index of the requester that produced res_dato.
- ocupado  out  1  high whenever the FSM is not in LIBRE.

## Operation
- Op codes, all bitwise over ANCHO bits:
  - 0 AND a&b; 1 OR a|b; 2 XOR a^b; 3 NOT ~a (b ignored).
  - 4 NAND ~(a&b); 5 YES b (a ignored); 6 NOR ~(a|b); 7 XNOR ~(a^b).
- FSM states: LIBRE, CALCULO, ENTREGA.
- LIBRE:
  - Grant logic is combinational. solN_listo = 1 only for the winner, and only when that requester's solN_valido = 1.
  - With one valid requester, it wins.
  - With both valid, the requester not recorded in the priority pointer wins (round-robin).
  - On acceptance (valido & listo), latch op, a, b and the requester index, then go to CALCULO.
- CALCULO:
  - Compute from the latched values.
  - Register res_dato and res_origen, set res_valido = 1, go to ENTREGA.
- ENTREGA:
  - res_dato, res_origen and res_valido stay stable while res_listo = 0.
  - On res_valido & res_listo: clear res_valido, write the served index into the priority pointer, go to LIBRE.
- sol0_listo and sol1_listo are 0 in CALCULO and ENTREGA; requests wait with no loss.
- Requester inputs may change after acceptance; the latched copy is used.
- There is no output bypass. A new request is considered only once LIBRE is re-entered.

## Timing
- Reset values:
  - State LIBRE; res_valido 0; res_dato 0; res_origen 0; ocupado 0.
  - Priority pointer = 1, so requester 0 wins the first tie.
  - sol0_listo and sol1_listo follow the LIBRE grant rule.
- Reset mid-operation:
  - Asynchronous clear of all of the above.
  - Any in-flight transaction is discarded and res_valido falls immediately.
- Latency: request accepted at edge k; res_valido = 1 after edge k+1.
- Minimum spacing: with res_listo held high, the result is consumed at edge k+2. The next grant can be accepted at edge k+3, giving one transaction per 3 cycles.
- Back-to-back ties alternate grants 0,1,0,1,…
- Simultaneous events:
  - In the ENTREGA cycle where res_listo is accepted, no grant is issued.
  - Requests asserted that cycle are evaluated in the following LIBRE cycle using the updated pointer.

## Configuration
- ARBITRO_PRIORIDAD_FIJA_EN defined: requester 0 always wins a tie. The priority pointer is not implemented, and requester 1 is served only when sol0_valido = 0 in LIBRE.
- Not defined (default): round-robin as described above.

## Test plan
- Reset check: assert reinicio with both requesters valid -> res_valido 0, res_dato 0, ocupado 0, sol0_listo = sol1_listo = 0 during reset. First tie after release grants requester 0.
- Single request: sol0 op=0, a=1100, b=1010, res_listo=1 -> sol0_listo high for 1 cycle. One cycle after the accepting edge: res_dato=1000, res_origen=0, res_valido=1 for exactly 1 cycle.
- Op sweep on requester 1 with a=0101, b=0011 over ops 0..7 -> 0001, 0111, 0110, 1010, 1110, 0011, 1000, 1001, each with res_origen=1.
- Continuous tie: both valid for 4 transactions, sol0 op=2 and sol1 op=4 -> origins 0,1,0,1. With ARBITRO_PRIORIDAD_FIJA_EN defined -> origins 0,0,0,0.
- Backpressure: hold res_listo=0 for 5 cycles with both requesters valid -> res_dato and res_origen stable, ocupado=1, both listo 0. Release -> result consumed, next grant one cycle later.
- Reset mid-ENTREGA: assert reinicio between edges -> res_valido drops without a clock edge. After release, state is LIBRE and the priority pointer is back at its reset value.

Source files
------------

// File: rtl/arbitro_compuertas.sv
// Two-requester arbiter feeding a registered 8-operation bitwise gate unit.
// Define ARBITRO_PRIORIDAD_FIJA_EN for fixed priority (requester 0 wins ties); default is round-robin.
module arbitro_compuertas #(
  parameter int ANCHO = 4
) (
  input  logic             reloj,
  input  logic             reinicio,
  input  logic             sol0_valido,
  output logic             sol0_listo,
  input  logic [2:0]       sol0_op,
  input  logic [ANCHO-1:0] sol0_a,
  input  logic [ANCHO-1:0] sol0_b,
  input  logic             sol1_valido,
  output logic             sol1_listo,
  input  logic [2:0]       sol1_op,
  input  logic [ANCHO-1:0] sol1_a,
  input  logic [ANCHO-1:0] sol1_b,
  output logic             res_valido,
  input  logic             res_listo,
  output logic [ANCHO-1:0] res_dato,
  output logic             res_origen,
  output logic             ocupado,
  output logic [1:0]       estado
);

  // Handshakes: a transfer happens on a rising edge where valido & listo are both 1.
  // Requester side: listo is combinational, only in LIBRE. Result side: res_valido is held until res_listo.
  typedef enum logic [1:0] {
    LIBRE   = 2'd0,
    CALCULO = 2'd1,
    ENTREGA = 2'd2
  } estado_t;

  estado_t          estado_q;
  logic [2:0]       lat_op;
  logic [ANCHO-1:0] lat_a;
  logic [ANCHO-1:0] lat_b;
  logic             lat_idx;
  logic             gana1;
  logic             gana0;
  logic             libre;

`ifdef ARBITRO_PRIORIDAD_FIJA_EN
  assign gana1 = sol1_valido & ~sol0_valido;
`else
  // Pointer holds the last requester served; the other one wins a tie.
  logic puntero;
  assign gana1 = sol1_valido & (~sol0_valido | ~puntero);
`endif
  assign gana0 = sol0_valido & ~gana1;

  // Grants are withheld while reset is asserted so nothing appears accepted.
  assign libre      = (estado_q == LIBRE) & ~reinicio;
  assign sol0_listo = libre & gana0;
  assign sol1_listo = libre & gana1;
  assign ocupado    = (estado_q != LIBRE);
  assign estado     = estado_q;

  function automatic logic [ANCHO-1:0] calcular(input logic [2:0] op,
                                                input logic [ANCHO-1:0] a,
                                                input logic [ANCHO-1:0] b);
    logic [ANCHO-1:0] r;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~a;
      3'd4:    r = ~(a & b);
      3'd5:    r = b;
      3'd6:    r = ~(a | b);
      default: r = ~(a ^ b);
    endcase
    return r;
  endfunction

  always_ff @(posedge reloj or posedge reinicio) begin
    if (reinicio) begin
      estado_q   <= LIBRE;
      res_valido <= 1'b0;
      res_dato   <= '0;
      res_origen <= 1'b0;
      lat_op     <= 3'd0;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_idx    <= 1'b0;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
      puntero    <= 1'b1;
`endif
    end else begin
      case (estado_q)
        LIBRE: begin
          if (sol0_listo | sol1_listo) begin
            lat_op   <= sol1_listo ? sol1_op : sol0_op;
            lat_a    <= sol1_listo ? sol1_a  : sol0_a;
            lat_b    <= sol1_listo ? sol1_b  : sol0_b;
            lat_idx  <= sol1_listo;
            estado_q <= CALCULO;
          end
        end
        CALCULO: begin
          res_dato   <= calcular(lat_op, lat_a, lat_b);
          res_origen <= lat_idx;
          res_valido <= 1'b1;
          estado_q   <= ENTREGA;
        end
        ENTREGA: begin
          if (res_listo) begin
            res_valido <= 1'b0;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
            puntero    <= res_origen;
`endif
            estado_q   <= LIBRE;
          end
        end
        default: estado_q <= LIBRE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_compuertas.sv
// Directed bench for arbitro_compuertas: reset, op sweep, ties, backpressure, mid-result reset.
module tb_arbitro_compuertas;

  localparam int ANCHO = 4;

  logic             reloj;
  logic             reinicio;
  logic             sol0_valido, sol0_listo;
  logic [2:0]       sol0_op;
  logic [ANCHO-1:0] sol0_a, sol0_b;
  logic             sol1_valido, sol1_listo;
  logic [2:0]       sol1_op;
  logic [ANCHO-1:0] sol1_a, sol1_b;
  logic             res_valido, res_listo;
  logic [ANCHO-1:0] res_dato;
  logic             res_origen;
  logic             ocupado;
  logic [1:0]       estado;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [0:0] exp_q[$];
  logic [3:0] exp_tab[8];

  arbitro_compuertas #(.ANCHO(ANCHO)) dut (
    .reloj(reloj), .reinicio(reinicio),
    .sol0_valido(sol0_valido), .sol0_listo(sol0_listo), .sol0_op(sol0_op),
    .sol0_a(sol0_a), .sol0_b(sol0_b),
    .sol1_valido(sol1_valido), .sol1_listo(sol1_listo), .sol1_op(sol1_op),
    .sol1_a(sol1_a), .sol1_b(sol1_b),
    .res_valido(res_valido), .res_listo(res_listo), .res_dato(res_dato),
    .res_origen(res_origen), .ocupado(ocupado), .estado(estado)
  );

  // Clock / watchdog
  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Driver / check tasks
  task automatic paso();
    @(posedge reloj);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic       fija;
  logic [0:0] o;

  initial begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    fija = 1'b1;
`else
    fija = 1'b0;
`endif
    exp_tab = '{4'b0001, 4'b0111, 4'b0110, 4'b1010, 4'b1110, 4'b0011, 4'b1000, 4'b1001};

    // Reset with both requesters valid
    reinicio    = 1'b1;
    sol0_valido = 1'b1; sol0_op = 3'd0; sol0_a = 4'b1100; sol0_b = 4'b1010;
    sol1_valido = 1'b1; sol1_op = 3'd1; sol1_a = 4'b0000; sol1_b = 4'b0000;
    res_listo   = 1'b1;
    paso(); paso();
    chk("rst_res_valido", {7'd0, res_valido}, 8'd0);
    chk("rst_res_dato",   {4'd0, res_dato},   8'd0);
    chk("rst_ocupado",    {7'd0, ocupado},    8'd0);
    chk("rst_sol0_listo", {7'd0, sol0_listo}, 8'd0);
    chk("rst_sol1_listo", {7'd0, sol1_listo}, 8'd0);
    chk("rst_estado",     {6'd0, estado},     8'd0);
    reinicio = 1'b0;
    #1;
    chk("tie0_sol0_listo", {7'd0, sol0_listo}, 8'd1);
    chk("tie0_sol1_listo", {7'd0, sol1_listo}, 8'd0);

    // Single request from requester 0: AND 1100 & 1010
    sol1_valido = 1'b0;
    paso();
    sol0_valido = 1'b0;
    sol0_a = 4'b1111; sol0_b = 4'b1111;
    chk("single_calc_estado",  {6'd0, estado},     8'd1);
    chk("single_calc_listo",   {7'd0, sol0_listo}, 8'd0);
    chk("single_calc_ocupado", {7'd0, ocupado},    8'd1);
    chk("single_calc_valido",  {7'd0, res_valido}, 8'd0);
    paso();
    chk("single_res_valido", {7'd0, res_valido}, 8'd1);
    chk("single_res_dato",   {4'd0, res_dato},   8'b1000);
    chk("single_res_origen", {7'd0, res_origen}, 8'd0);
    paso();
    chk("single_consumed_valido", {7'd0, res_valido}, 8'd0);
    chk("single_consumed_estado", {6'd0, estado},     8'd0);

    // Op sweep on requester 1 with a=0101, b=0011
    for (int k = 0; k < 8; k++) begin
      sol1_valido = 1'b1; sol1_op = 3'(k); sol1_a = 4'b0101; sol1_b = 4'b0011;
      #1;
      chk($sformatf("sweep%0d_listo", k), {7'd0, sol1_listo}, 8'd1);
      paso();
      sol1_valido = 1'b0; sol1_a = 4'b0000; sol1_b = 4'b0000;
      paso();
      chk($sformatf("sweep%0d_dato", k),   {4'd0, res_dato},   {4'd0, exp_tab[k]});
      chk($sformatf("sweep%0d_origen", k), {7'd0, res_origen}, 8'd1);
      chk($sformatf("sweep%0d_valido", k), {7'd0, res_valido}, 8'd1);
      paso();
    end

    // Continuous tie: sol0 XOR -> 0110, sol1 NAND -> 0111
    sol0_op = 3'd2; sol0_a = 4'b1100; sol0_b = 4'b1010;
    sol1_op = 3'd4; sol1_a = 4'b1100; sol1_b = 4'b1010;
    sol0_valido = 1'b1; sol1_valido = 1'b1;
    if (fija) exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
    else      exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("tie%0d_estado_libre", k), {6'd0, estado}, 8'd0);
      paso();
      paso();
      o = exp_q.pop_front();
      chk($sformatf("tie%0d_origen", k), {7'd0, res_origen}, {7'd0, o});
      chk($sformatf("tie%0d_dato", k),   {4'd0, res_dato},   o ? 8'b0111 : 8'b0110);
      chk($sformatf("tie%0d_no_grant", k), {6'd0, sol1_listo, sol0_listo}, 8'd0);
      paso();
    end

    // Backpressure: requester 0 wins (pointer=1 or fixed priority)
    res_listo = 1'b0;
    paso();
    paso();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp%0d_valido", k),  {7'd0, res_valido}, 8'd1);
      chk($sformatf("bp%0d_dato", k),    {4'd0, res_dato},   8'b0110);
      chk($sformatf("bp%0d_origen", k),  {7'd0, res_origen}, 8'd0);
      chk($sformatf("bp%0d_ocupado", k), {7'd0, ocupado},    8'd1);
      chk($sformatf("bp%0d_listos", k),  {6'd0, sol1_listo, sol0_listo}, 8'd0);
      paso();
    end
    res_listo = 1'b1;
    paso();
    chk("bp_release_valido", {7'd0, res_valido}, 8'd0);
    chk("bp_release_grant",  {6'd0, sol1_listo, sol0_listo}, fija ? 8'b01 : 8'b10);
    paso();
    chk("bp_next_estado", {6'd0, estado}, 8'd1);
    sol0_valido = 1'b0; sol1_valido = 1'b0;
    res_listo = 1'b0;
    paso();
    chk("bp_next_origen", {7'd0, res_origen}, fija ? 8'd0 : 8'd1);
    chk("bp_next_valido", {7'd0, res_valido}, 8'd1);

    // Asynchronous reset while in ENTREGA, between clock edges
    #3;
    reinicio = 1'b1;
    #1;
    chk("mid_rst_valido",  {7'd0, res_valido}, 8'd0);
    chk("mid_rst_dato",    {4'd0, res_dato},   8'd0);
    chk("mid_rst_estado",  {6'd0, estado},     8'd0);
    chk("mid_rst_ocupado", {7'd0, ocupado},    8'd0);
    #1;
    reinicio = 1'b0;
    sol0_valido = 1'b1; sol1_valido = 1'b1;
    res_listo = 1'b1;
    #1;
    chk("mid_rst_tie_grant", {6'd0, sol1_listo, sol0_listo}, 8'b01);
    paso();
    sol0_valido = 1'b0; sol1_valido = 1'b0;
    paso();
    chk("mid_rst_after_origen", {7'd0, res_origen}, 8'd0);
    chk("mid_rst_after_dato",   {4'd0, res_dato},   8'b0110);
    paso();
    chk("final_estado", {6'd0, estado}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
